// File: rtl/i2c_master.sv
// Single-byte I2C initiator: one write or read per command, START/addr/ACK/data/STOP
// sequenced with a 4-quarter bit timing. SDA is open-drain (drive low or release).
module i2c_master #(
    parameter int SYS_FREQ = 40_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);

    localparam int BIT = SYS_FREQ / I2C_FREQ;
    localparam int QTR = BIT / 4;
    localparam int CW  = $clog2(BIT);

    localparam logic [CW-1:0] CNT_QTR  = CW'(QTR);
    localparam logic [CW-1:0] CNT_HALF = CW'(2 * QTR);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WR_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_DATA_ACK,
        S_RD_DATA,
        S_M_NACK,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    din_q, din_d;
    logic          op_q, op_d;
    logic [7:0]    dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;

    logic sda_in;
    logic end_of_bit;
    logic low_half;
    logic drive_pt;
    logic sample_pt;

    // Open-drain SDA: only ever pulls low; the external pull-up supplies the 1.
    assign sda    = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign scl     = scl_q;
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;
    assign done    = done_q;

    assign end_of_bit = (cnt_q == CNT_LAST);
    assign low_half   = (cnt_q < CNT_HALF);
    assign drive_pt   = (cnt_q == CNT_QTR);
    assign sample_pt  = (cnt_q == CNT_HALF);

    // Next-state, bit timing and bus output decode for every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        din_d     = din_q;
        op_d      = op_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;

        if (busy_q) begin
            cnt_d = end_of_bit ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
                // The done cycle also blocks acceptance so a command cannot overlap completion.
                if (newd && !busy_q && !done_q) begin
                    op_d      = op;
                    din_d     = din;
                    tx_d      = {addr, op};
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_d     = '0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                // SDA falls in the second half while SCL stays high.
                scl_d    = 1'b1;
                sda_oe_d = !low_half;
                if (end_of_bit) begin
                    bit_d   = '0;
                    state_d = S_WR_ADDR;
                end
            end

            S_WR_ADDR, S_WR_DATA: begin
                scl_d = !low_half;
                if (drive_pt) begin
                    sda_oe_d = !tx_q[7];
                end
                if (end_of_bit) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == S_WR_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                    end
                end
            end

            S_ADDR_ACK: begin
                scl_d = !low_half;
                if (drive_pt) begin
                    sda_oe_d = 1'b0;
                end
                if (sample_pt && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (end_of_bit) begin
                    bit_d = '0;
                    tx_d  = din_q;
                    if (ack_err_q) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = op_q ? S_RD_DATA : S_WR_DATA;
                    end
                end
            end

            S_DATA_ACK: begin
                scl_d = !low_half;
                if (drive_pt) begin
                    sda_oe_d = 1'b0;
                end
                if (sample_pt && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (end_of_bit) begin
                    state_d = S_STOP;
                end
            end

            S_RD_DATA: begin
                scl_d = !low_half;
                if (drive_pt) begin
                    sda_oe_d = 1'b0;
                end
                if (sample_pt) begin
                    dout_d = {dout_q[6:0], sda_in};
                end
                if (end_of_bit) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_M_NACK;
                    end
                end
            end

            S_M_NACK: begin
                // Leaving SDA released is the NACK that ends a single-byte read.
                scl_d = !low_half;
                if (drive_pt) begin
                    sda_oe_d = 1'b0;
                end
                if (end_of_bit) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                // SDA rises in the second half while SCL is high.
                scl_d    = (cnt_q >= CNT_QTR);
                sda_oe_d = low_half;
                if (end_of_bit) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                cnt_d    = '0;
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and registered bus/host outputs; reset aborts straight to an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            din_q     <= '0;
            op_q      <= 1'b0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            din_q     <= din_d;
            op_q      <= op_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a bus-level slave model and scoreboard queues
// for bus bytes and per-transaction results.
module tb_i2c_master;

    localparam int BIT = 400;
    localparam int QTR = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       newd = 1'b0;
    logic       op = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] din = '0;
    logic       scl;
    wire        sda;
    logic [7:0] dout;
    logic       busy;
    logic       ack_err;
    logic       done;

    i2c_master #(.SYS_FREQ(40_000_000), .I2C_FREQ(100_000)) dut (
        .clk(clk), .rst(rst), .newd(newd), .op(op), .addr(addr), .din(din),
        .scl(scl), .sda(sda), .dout(dout), .busy(busy), .ack_err(ack_err), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards
    logic [7:0] exp_bytes[$];
    typedef struct {
        logic       ack_err;
        logic [7:0] dout;
        int         lat;
    } res_t;
    res_t exp_res[$];

    // Bus-level slave model
    localparam int M_IDLE = 0, M_ADDR = 1, M_AACK = 2, M_WDATA = 3, M_DACK = 4, M_RDATA = 5, M_MACK = 6;
    logic       sda_low = 1'b0;
    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    logic       slave_present = 1'b1;
    logic       nack_data = 1'b0;
    logic [7:0] mem [128];
    logic       m_ack_bit;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         s_mode = M_IDLE;
    int         s_bits = 0;
    logic [7:0] s_sr = '0;
    logic [7:0] rbyte = '0;
    logic [6:0] cur_addr = '0;
    logic       cur_rw = 1'b0;

    function automatic logic sda_level();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic got_byte(input logic [7:0] b);
        logic [31:0] e;
        e = (exp_bytes.size() > 0) ? {24'h0, exp_bytes.pop_front()} : 32'hDEAD;
        check("bus_byte", {24'h0, b}, e);
    endtask

    // Sampled on the falling clock edge so the DUT's registered outputs are settled.
    always @(negedge clk) begin
        logic s;
        s = sda_level();
        if (scl && scl_p && sda_p && !s) begin
            s_mode  = M_ADDR;
            s_bits  = 0;
            sda_low = 1'b0;
        end else if (scl && scl_p && !sda_p && s) begin
            s_mode  = M_IDLE;
            sda_low = 1'b0;
        end else if (scl && !scl_p) begin
            case (s_mode)
                M_ADDR, M_WDATA: begin
                    s_sr = {s_sr[6:0], s};
                    s_bits++;
                    if (s_bits == 8) got_byte(s_sr);
                end
                M_RDATA: s_bits++;
                M_MACK: begin
                    m_ack_bit = s;
                    s_mode = M_IDLE;
                end
                default: ;
            endcase
        end else if (!scl && scl_p) begin
            case (s_mode)
                M_ADDR: if (s_bits == 8) begin
                    if (slave_present) begin
                        cur_addr = s_sr[7:1];
                        cur_rw   = s_sr[0];
                        sda_low  = 1'b1;
                        s_mode   = M_AACK;
                    end else begin
                        s_mode = M_IDLE;
                    end
                end
                M_AACK: begin
                    s_bits = 0;
                    if (cur_rw) begin
                        rbyte   = mem[cur_addr];
                        sda_low = !rbyte[7];
                        s_mode  = M_RDATA;
                    end else begin
                        sda_low = 1'b0;
                        s_mode  = M_WDATA;
                    end
                end
                M_WDATA: if (s_bits == 8) begin
                    mem[cur_addr] = s_sr;
                    sda_low = !nack_data;
                    s_mode  = M_DACK;
                end
                M_DACK: begin
                    sda_low = 1'b0;
                    s_mode  = M_IDLE;
                end
                M_RDATA: begin
                    if (s_bits == 8) begin
                        sda_low = 1'b0;
                        s_mode  = M_MACK;
                    end else begin
                        sda_low = !rbyte[7 - s_bits];
                    end
                end
                default: ;
            endcase
        end
        scl_p = scl;
        sda_p = s;
    end

    int accept_cyc = 0;

    task automatic issue(input logic o, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        op = o; addr = a; din = d; newd = 1'b1;
        @(posedge clk);
        #1;
        newd = 1'b0;
        accept_cyc = cyc;
        check("busy_on_accept", {31'h0, busy}, 32'h1);
        check("ack_err_cleared", {31'h0, ack_err}, 32'h0);
    endtask

    task automatic wait_done(input string name);
        res_t r;
        int lat;
        do begin
            @(posedge clk);
            #1;
        end while (done !== 1'b1 && (cyc - accept_cyc) < 30000);
        lat = cyc - accept_cyc;
        r = exp_res.pop_front();
        check({name, "_latency"}, lat, r.lat);
        check({name, "_ack_err"}, {31'h0, ack_err}, {31'h0, r.ack_err});
        check({name, "_dout"}, {24'h0, dout}, {24'h0, r.dout});
        check({name, "_busy_low"}, {31'h0, busy}, 32'h0);
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        $display("txn %s: latency=%0d ack_err=%0b dout=0x%02h", name, lat, ack_err, dout);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl", {31'h0, scl}, 32'h1);
        check("rst_sda", {31'h0, sda_level()}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ack_err", {31'h0, ack_err}, 32'h0);
        check("rst_dout", {24'h0, dout}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Write 0x55 to 0x12
        exp_bytes.push_back(8'h24); exp_bytes.push_back(8'h55);
        exp_res.push_back('{ack_err: 1'b0, dout: 8'h00, lat: 20 * BIT});
        issue(1'b0, 7'h12, 8'h55);
        wait_done("write");
        check("mem_after_write", {24'h0, mem[7'h12]}, 32'h55);

        // Read 0x12, slave returns 0xA5
        mem[7'h12] = 8'hA5;
        m_ack_bit = 1'bx;
        exp_bytes.push_back(8'h25);
        exp_res.push_back('{ack_err: 1'b0, dout: 8'hA5, lat: 20 * BIT});
        issue(1'b1, 7'h12, 8'h00);
        wait_done("read");
        check("read_master_nack", {31'h0, m_ack_bit}, 32'h1);

        // Address NACK, no slave
        slave_present = 1'b0;
        exp_bytes.push_back(8'h60);
        exp_res.push_back('{ack_err: 1'b1, dout: 8'hA5, lat: 11 * BIT});
        issue(1'b0, 7'h30, 8'h11);
        wait_done("addr_nack");
        check("stop_sda_idle", {31'h0, sda_level()}, 32'h1);
        slave_present = 1'b1;

        // Data NACK
        nack_data = 1'b1;
        exp_bytes.push_back(8'h24); exp_bytes.push_back(8'h77);
        exp_res.push_back('{ack_err: 1'b1, dout: 8'hA5, lat: 20 * BIT});
        issue(1'b0, 7'h12, 8'h77);
        wait_done("data_nack");
        nack_data = 1'b0;

        // newd re-pulsed mid-transaction is ignored
        exp_bytes.push_back(8'h24); exp_bytes.push_back(8'h3C);
        exp_res.push_back('{ack_err: 1'b0, dout: 8'hA5, lat: 20 * BIT});
        issue(1'b0, 7'h12, 8'h3C);
        repeat (2000) @(posedge clk);
        @(negedge clk);
        op = 1'b1; addr = 7'h55; din = 8'hFF; newd = 1'b1;
        @(negedge clk);
        newd = 1'b0;
        wait_done("repulse");
        check("mem_after_repulse", {24'h0, mem[7'h12]}, 32'h3C);

        // Reset during bit 5 of the address byte
        issue(1'b0, 7'h12, 8'h99);
        repeat (6 * BIT + 2 * QTR) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", {31'h0, scl}, 32'h1);
        check("abort_sda", {31'h0, sda_level()}, 32'h1);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_dout", {24'h0, dout}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Following write then read back
        exp_bytes.push_back(8'h24); exp_bytes.push_back(8'h5A);
        exp_res.push_back('{ack_err: 1'b0, dout: 8'h00, lat: 20 * BIT});
        issue(1'b0, 7'h12, 8'h5A);
        wait_done("write_after_rst");
        exp_bytes.push_back(8'h25);
        exp_res.push_back('{ack_err: 1'b0, dout: 8'h5A, lat: 20 * BIT});
        issue(1'b1, 7'h12, 8'h00);
        wait_done("readback");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
